// File: rtl/etapa3_iterativa_pkg.sv
// Shared widths and FSM encoding for the iterative divider stage.
package etapa3_iterativa_pkg;

  localparam int DV_MSB = 15;
  localparam int DD_MSB = 31;
  localparam int Q_MSB  = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/etapa3_iterativa_paso.sv
// One restoring shift-subtract step: the work register holds the partial remainder in its
// upper half and shifts quotient bits into its lower half.
module etapa3_iterativa_paso #(
  parameter int AnchoDv = 15,
  parameter int AnchoDd = 31
) (
  input  logic [AnchoDd:0] w,
  input  logic [AnchoDv:0] d,
  output logic [AnchoDd:0] w_next
);

  localparam int DL = AnchoDv + 1;

  logic [DL:0]   hi;
  logic [DL-1:0] diff;
  logic          fits;

  // hi is the upper 17 bits of {w,1'b0}; its MSB only matters for the compare.
  always_comb begin
    hi   = w[AnchoDd:AnchoDv];
    fits = (hi >= {1'b0, d});
    diff = hi[DL-1:0] - d;
    if (fits) w_next = {diff, w[AnchoDv-1:0], 1'b1};
    else      w_next = {w[AnchoDd-1:0], 1'b0};
  end

endmodule

// File: rtl/etapa3_iterativa.sv
// Divider stage 3: unsigned restoring division on magnitudes, one quotient bit per clock,
// with an early-out for divide-by-zero and quotient overflow.
module etapa3_iterativa
  import etapa3_iterativa_pkg::*;
#(
  parameter int AnchoDv = DV_MSB,
  parameter int AnchoDd = DD_MSB,
  parameter int AnchoQ  = Q_MSB
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             goIn,
  input  logic [AnchoDv:0] divisorIn,
  input  logic [AnchoDd:0] dividendIn,
  input  logic             negDivisorIn,
  input  logic             negDividendIn,
  input  logic             DivisorNoCeroIn,
  output logic             readyOut,
  output logic             goOut,
  output logic [AnchoQ:0]  quotientOut,
  output logic [AnchoQ:0]  remainderOut,
  output logic             negDivisorOut,
  output logic             negDividendOut,
  output logic             DivisorNoCeroOut,
  output logic             overflowOut,
  output logic             dropOut
);

  localparam int                CNT_W    = $clog2(AnchoQ + 1);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(AnchoQ);

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt;
  logic [AnchoDd:0]   w, w_step;
  logic [AnchoDv:0]   d;
  logic               neg_dv, neg_dd, no_cero;
  logic               skip, capture, load_skip, load_run;

  // Quotient cannot fit when the high dividend half already reaches the divisor.
  assign skip = !DivisorNoCeroIn || (dividendIn[AnchoDd:AnchoDv+1] >= divisorIn);

  etapa3_iterativa_paso #(
    .AnchoDv (AnchoDv),
    .AnchoDd (AnchoDd)
  ) u_paso (
    .w      (w),
    .d      (d),
    .w_next (w_step)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (goIn) state_nx = skip ? DONE : RUN;
      RUN:     if (cnt == CNT_LAST) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    readyOut  = (state == IDLE);
    capture   = readyOut && goIn;
    load_skip = capture && skip;
    load_run  = (state == RUN) && (cnt == CNT_LAST);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)            cnt <= '0;
    else if (capture)      cnt <= '0;
    else if (state == RUN) cnt <= cnt + 1'b1;
  end

  // Operand and work registers carry data only; their contents are irrelevant in IDLE.
  always_ff @(posedge clk) begin
    if (capture) begin
      w       <= dividendIn;
      d       <= divisorIn;
      neg_dv  <= negDivisorIn;
      neg_dd  <= negDividendIn;
      no_cero <= DivisorNoCeroIn;
    end else if (state == RUN) begin
      w <= w_step;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      goOut            <= 1'b0;
      quotientOut      <= '0;
      remainderOut     <= '0;
      negDivisorOut    <= 1'b0;
      negDividendOut   <= 1'b0;
      DivisorNoCeroOut <= 1'b0;
      overflowOut      <= 1'b0;
      dropOut          <= 1'b0;
    end else begin
      goOut <= load_skip || load_run;
      if (load_skip) begin
        quotientOut      <= '1;
        remainderOut     <= dividendIn[AnchoDd:AnchoDv+1];
        overflowOut      <= 1'b1;
        negDivisorOut    <= negDivisorIn;
        negDividendOut   <= negDividendIn;
        DivisorNoCeroOut <= DivisorNoCeroIn;
      end else if (load_run) begin
        quotientOut      <= w_step[AnchoQ:0];
        remainderOut     <= w_step[AnchoDd:AnchoQ+1];
        overflowOut      <= 1'b0;
        negDivisorOut    <= neg_dv;
        negDividendOut   <= neg_dd;
        DivisorNoCeroOut <= no_cero;
      end
      if (goIn && !readyOut) dropOut <= 1'b1;
    end
  end

endmodule

// File: tb/tb_etapa3_iterativa.sv
// Randomized bench for etapa3_iterativa with a cycle-level reference model of results and timing.
module tb_etapa3_iterativa;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        goIn = 1'b0;
  logic [15:0] divisorIn = '0;
  logic [31:0] dividendIn = '0;
  logic        negDivisorIn = 1'b0, negDividendIn = 1'b0, DivisorNoCeroIn = 1'b0;
  logic        readyOut, goOut, negDivisorOut, negDividendOut, DivisorNoCeroOut;
  logic        overflowOut, dropOut;
  logic [15:0] quotientOut, remainderOut;

  int checks = 0;
  int failures = 0;

  etapa3_iterativa dut (
    .clk              (clk),
    .reset            (reset),
    .goIn             (goIn),
    .divisorIn        (divisorIn),
    .dividendIn       (dividendIn),
    .negDivisorIn     (negDivisorIn),
    .negDividendIn    (negDividendIn),
    .DivisorNoCeroIn  (DivisorNoCeroIn),
    .readyOut         (readyOut),
    .goOut            (goOut),
    .quotientOut      (quotientOut),
    .remainderOut     (remainderOut),
    .negDivisorOut    (negDivisorOut),
    .negDividendOut   (negDividendOut),
    .DivisorNoCeroOut (DivisorNoCeroOut),
    .overflowOut      (overflowOut),
    .dropOut          (dropOut)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: n counts clock edges; go_edge is the edge after which goOut must be high.
  int          n = 0;
  int          go_edge = -1;
  logic [15:0] pq, pr, eq = '0, er = '0;
  logic        povf, pndv, pndd, pnz;
  logic        eovf = 0, endv = 0, endd = 0, enz = 0, m_drop = 0, m_ready;

  always @(negedge clk) begin
    n++;
    if (!reset) begin
      go_edge = -1;
      m_drop  = 0;
      eq = '0; er = '0; eovf = 0; endv = 0; endd = 0; enz = 0;
      chk("rst_ready", readyOut, 1);
      chk("rst_go", goOut, 0);
      chk("rst_q", quotientOut, 0);
      chk("rst_r", remainderOut, 0);
      chk("rst_flags", {overflowOut, dropOut, negDivisorOut, negDividendOut, DivisorNoCeroOut}, 0);
    end else begin
      m_ready = (n > go_edge);
      if (n == go_edge) begin
        eq = pq; er = pr; eovf = povf; endv = pndv; endd = pndd; enz = pnz;
      end
      chk("ready", readyOut, m_ready);
      chk("go", goOut, n == go_edge);
      chk("quotient", quotientOut, eq);
      chk("remainder", remainderOut, er);
      chk("overflow", overflowOut, eovf);
      chk("flags", {negDivisorOut, negDividendOut, DivisorNoCeroOut}, {endv, endd, enz});
      chk("drop", dropOut, m_drop);
      // Inputs presented now are sampled at edge n+1.
      if (goIn) begin
        if (m_ready) begin
          pndv = negDivisorIn; pndd = negDividendIn; pnz = DivisorNoCeroIn;
          if (!DivisorNoCeroIn || dividendIn[31:16] >= divisorIn) begin
            pq = 16'hFFFF; pr = dividendIn[31:16]; povf = 1; go_edge = n + 1;
          end else begin
            pq = 16'(dividendIn / divisorIn);
            pr = 16'(dividendIn % divisorIn);
            povf = 0; go_edge = n + 17;
          end
        end else begin
          m_drop = 1;
        end
      end
    end
  end

  task automatic send(input logic [31:0] dd, input logic [15:0] dv,
                      input logic ndv, input logic ndd, input logic nz);
    int k = 0;
    @(posedge clk); #1;
    while (!readyOut && k < 100) begin @(posedge clk); #1; k++; end
    if (k >= 100) chk("ready_timeout", readyOut, 1);
    dividendIn = dd; divisorIn = dv;
    negDivisorIn = ndv; negDividendIn = ndd; DivisorNoCeroIn = nz;
    goIn = 1'b1;
    @(posedge clk); #1;
    goIn = 1'b0;
  endtask

  task automatic wait_go(output int lat);
    lat = 0;
    do begin @(negedge clk); lat++; end while (!goOut && lat < 40);
  endtask

  initial begin
    int lat;
    logic [15:0] dv, hi, lo;
    #1000000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    logic [15:0] dv, hi, lo;
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    send(32'd100, 16'd7, 0, 0, 1);
    wait_go(lat);
    chk("t1_lat", lat, 17); chk("t1_q", quotientOut, 14);
    chk("t1_r", remainderOut, 2); chk("t1_ovf", overflowOut, 0);

    send(32'h7FFF_FFFF, 16'hFFFF, 0, 0, 1);
    wait_go(lat);
    chk("t2_q", quotientOut, 16'h8000); chk("t2_r", remainderOut, 16'h7FFF);

    send(32'd55, 16'd0, 0, 1, 0);
    wait_go(lat);
    chk("t3_lat", lat, 1); chk("t3_q", quotientOut, 16'hFFFF);
    chk("t3_r", remainderOut, 0); chk("t3_ovf", overflowOut, 1);
    chk("t3_nz", DivisorNoCeroOut, 0);

    send(32'h0007_0000, 16'd7, 0, 0, 1);
    wait_go(lat);
    chk("t4a_lat", lat, 1); chk("t4a_ovf", overflowOut, 1);
    send(32'h0006_FFFF, 16'd7, 0, 0, 1);
    wait_go(lat);
    chk("t4b_lat", lat, 17); chk("t4b_q", quotientOut, 16'hFFFF);
    chk("t4b_r", remainderOut, 6); chk("t4b_ovf", overflowOut, 0);

    for (int i = 0; i < 40; i++) begin
      dv = 16'($urandom);
      if ($urandom_range(0, 7) == 0) dv = 16'd0;
      hi = (dv != 0) ? 16'($urandom_range(0, int'(dv) - 1)) : 16'($urandom);
      if ($urandom_range(0, 5) == 0) hi = 16'($urandom);
      lo = 16'($urandom);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      send({hi, lo}, dv, 1'($urandom), 1'($urandom), dv != 0);
    end
    repeat (20) @(posedge clk);

    chk("t5_drop_pre", dropOut, 0);
    send(32'd100, 16'd7, 1, 0, 1);
    repeat (5) @(posedge clk);
    #1;
    dividendIn = 32'd999; divisorIn = 16'd3; goIn = 1'b1;
    @(posedge clk); #1;
    goIn = 1'b0;
    wait_go(lat);
    chk("t5_q", quotientOut, 14); chk("t5_r", remainderOut, 2);
    chk("t5_ndv", negDivisorOut, 1); chk("t5_ndd", negDividendOut, 0);
    chk("t5_drop", dropOut, 1);

    send(32'd100, 16'd7, 0, 0, 1);
    repeat (8) @(posedge clk);
    #1 reset = 1'b0;
    #1;
    chk("t6_ready", readyOut, 1); chk("t6_q", quotientOut, 0); chk("t6_drop", dropOut, 0);
    repeat (20) @(posedge clk);
    #1 reset = 1'b1;
    send(32'd100, 16'd7, 0, 0, 1);
    wait_go(lat);
    chk("t6_lat", lat, 17); chk("t6_q2", quotientOut, 14); chk("t6_r2", remainderOut, 2);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
